// File: rtl/full_adder_pkg.sv
// Shared types and constants for the full adder unit: BIST state encoding and golden table.
// Optional self-test is built when FULL_ADDER_BIST_EN is defined.
package full_adder_pkg;

    localparam int unsigned VEC_W   = 3;
    localparam int unsigned N_VEC   = 8;
    localparam int unsigned GOLD_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_e;

    // Indexed by {A,B,Cin}; each entry is {Sum,Cout}.
    localparam logic [GOLD_W-1:0] GOLDEN_TT [N_VEC] = '{
        2'b00, 2'b10, 2'b10, 2'b01,
        2'b10, 2'b01, 2'b01, 2'b11
    };

endpackage

// File: rtl/full_adder_unit_if.sv
// Operand/result and self-test signal bundle for full_adder_unit.
interface full_adder_unit_if;

    logic A;
    logic B;
    logic Cin;
    logic in_valid;
    logic Sum;
    logic Cout;
    logic out_valid;
    logic bist_start;
    logic bist_busy;
    logic bist_done;
    logic bist_fail;

    modport master (
        output A, B, Cin, in_valid, bist_start,
        input  Sum, Cout, out_valid, bist_busy, bist_done, bist_fail
    );

    modport slave (
        input  A, B, Cin, in_valid, bist_start,
        output Sum, Cout, out_valid, bist_busy, bist_done, bist_fail
    );

endinterface

// File: rtl/full_adder_cell.sv
// Purely combinational single-bit full adder cell.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum_c,
    output logic cout_c
);

    always_comb begin
        sum_c  = a ^ b ^ cin;
        cout_c = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/full_adder_unit.sv
// Registered single-bit full adder with optional exhaustive self-test.
// Self-test FSM is built only when FULL_ADDER_BIST_EN is defined.
module full_adder_unit
    import full_adder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    full_adder_unit_if.slave  bus
);

    logic cell_a;
    logic cell_b;
    logic cell_cin;
    logic cell_sum;
    logic cell_cout;

    logic sum_q, sum_d;
    logic cout_q, cout_d;
    logic out_valid_q, out_valid_d;

    full_adder_cell u_cell (
        .a      (cell_a),
        .b      (cell_b),
        .cin    (cell_cin),
        .sum_c  (cell_sum),
        .cout_c (cell_cout)
    );

`ifdef FULL_ADDER_BIST_EN

    bist_state_e       state_q, state_d;
    logic [VEC_W-1:0]  cnt_q, cnt_d;
    logic [VEC_W-1:0]  chk_idx_q, chk_idx_d;
    logic              chk_pend_q, chk_pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;

    // Operand mux: the vector counter owns the cell while the self-test runs.
    always_comb begin
        cell_a   = bus.A;
        cell_b   = bus.B;
        cell_cin = bus.Cin;
        if (state_q == RUN) begin
            {cell_a, cell_b, cell_cin} = cnt_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chk_idx_d   = chk_idx_q;
        chk_pend_d  = chk_pend_q;
        done_d      = done_q;
        fail_d      = fail_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.in_valid) begin
                    sum_d       = cell_sum;
                    cout_d      = cell_cout;
                    out_valid_d = 1'b1;
                end
                if (bus.bist_start) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    chk_pend_d = 1'b0;
                    done_d     = 1'b0;
                    fail_d     = 1'b0;
                end
            end
            RUN: begin
                // The result registered on the previous edge is checked on this one.
                if (chk_pend_q && ({sum_q, cout_q} != GOLDEN_TT[chk_idx_q])) begin
                    fail_d = 1'b1;
                end
                if (chk_pend_q && (chk_idx_q == VEC_W'(N_VEC - 1))) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    chk_pend_d = 1'b0;
                end else begin
                    sum_d      = cell_sum;
                    cout_d     = cell_cout;
                    chk_idx_d  = cnt_q;
                    chk_pend_d = 1'b1;
                    cnt_d      = cnt_q + VEC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            chk_idx_q  <= '0;
            chk_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chk_idx_q  <= chk_idx_d;
            chk_pend_q <= chk_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
        end
    end

    assign bus.bist_busy = busy_q;
    assign bus.bist_done = done_q;
    assign bus.bist_fail = fail_q;

`else

    always_comb begin
        cell_a   = bus.A;
        cell_b   = bus.B;
        cell_cin = bus.Cin;
    end

    always_comb begin
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            sum_d       = cell_sum;
            cout_d      = cell_cout;
            out_valid_d = 1'b1;
        end
    end

    assign bus.bist_busy = 1'b0;
    assign bus.bist_done = 1'b0;
    assign bus.bist_fail = 1'b0;

`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder_unit.sv
// Directed self-checking bench for full_adder_unit; self-test scenarios follow FULL_ADDER_BIST_EN.
module tb_full_adder_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    full_adder_unit_if bus_if ();

    full_adder_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed {Sum,Cout} for {A,B,Cin} = 0..7.
    logic [1:0] exp_tt [8];

    task automatic test_reset();
        #2 rst = 1'b1;
        #2;
        total++; if (bus_if.Sum !== 1'b0)       begin bad++; $display("FAIL reset_sum got=%b want=0", bus_if.Sum); end
        total++; if (bus_if.Cout !== 1'b0)      begin bad++; $display("FAIL reset_cout got=%b want=0", bus_if.Cout); end
        total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus_if.out_valid); end
        total++; if (bus_if.bist_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus_if.bist_busy); end
        total++; if (bus_if.bist_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus_if.bist_done); end
        total++; if (bus_if.bist_fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%b want=0", bus_if.bist_fail); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_exhaustive();
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {bus_if.A, bus_if.B, bus_if.Cin} = v;
            bus_if.in_valid = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({bus_if.Sum, bus_if.Cout, bus_if.out_valid} !== {exp_tt[i], 1'b1}) begin
                bad++;
                $display("FAIL exhaustive_%0d got sum/cout/vld=%b%b%b want=%b%b1",
                         i, bus_if.Sum, bus_if.Cout, bus_if.out_valid, exp_tt[i][1], exp_tt[i][0]);
            end
        end
        bus_if.in_valid = 1'b0;
    endtask

    task automatic test_hold();
        {bus_if.A, bus_if.B, bus_if.Cin} = 3'b110;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        {bus_if.A, bus_if.B, bus_if.Cin} = 3'b000;
        bus_if.in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            total++;
            if ({bus_if.Sum, bus_if.Cout, bus_if.out_valid} !== 3'b010) begin
                bad++;
                $display("FAIL hold_%0d got sum/cout/vld=%b%b%b want=010",
                         k, bus_if.Sum, bus_if.Cout, bus_if.out_valid);
            end
        end
    endtask

    task automatic test_async_reset();
        {bus_if.A, bus_if.B, bus_if.Cin} = 3'b100;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        total++;
        if ({bus_if.Sum, bus_if.out_valid} !== 2'b11) begin
            bad++;
            $display("FAIL async_pre got sum/vld=%b%b want=11", bus_if.Sum, bus_if.out_valid);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({bus_if.Sum, bus_if.Cout, bus_if.out_valid} !== 3'b000) begin
            bad++;
            $display("FAIL async_reset got sum/cout/vld=%b%b%b want=000",
                     bus_if.Sum, bus_if.Cout, bus_if.out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

`ifdef FULL_ADDER_BIST_EN

    task automatic test_bist_pass();
        bus_if.in_valid   = 1'b0;
        bus_if.bist_start = 1'b1;
        @(posedge clk); #1;
        bus_if.bist_start = 1'b0;
        total++;
        if ({bus_if.bist_busy, bus_if.bist_done} !== 2'b10) begin
            bad++;
            $display("FAIL bist_edge0 got busy/done=%b%b want=10", bus_if.bist_busy, bus_if.bist_done);
        end
        // Functional inputs and a second start are driven during the run and must be ignored.
        for (int k = 1; k <= 8; k++) begin
            {bus_if.A, bus_if.B, bus_if.Cin} = 3'b111;
            bus_if.in_valid   = 1'b1;
            bus_if.bist_start = (k == 4);
            @(posedge clk); #1;
            total++;
            if ({bus_if.bist_busy, bus_if.bist_done, bus_if.out_valid} !== 3'b100) begin
                bad++;
                $display("FAIL bist_run_%0d got busy/done/vld=%b%b%b want=100",
                         k, bus_if.bist_busy, bus_if.bist_done, bus_if.out_valid);
            end
        end
        bus_if.bist_start = 1'b0;
        bus_if.in_valid   = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({bus_if.bist_busy, bus_if.bist_done, bus_if.bist_fail, bus_if.out_valid} !== 4'b0100) begin
            bad++;
            $display("FAIL bist_done got busy/done/fail/vld=%b%b%b%b want=0100",
                     bus_if.bist_busy, bus_if.bist_done, bus_if.bist_fail, bus_if.out_valid);
        end
        total++;
        if ({bus_if.Sum, bus_if.Cout} !== 2'b11) begin
            bad++;
            $display("FAIL bist_last_vec got sum/cout=%b%b want=11", bus_if.Sum, bus_if.Cout);
        end
        @(posedge clk); #1;
        total++;
        if ({bus_if.bist_done, bus_if.bist_fail} !== 2'b10) begin
            bad++;
            $display("FAIL bist_sticky got done/fail=%b%b want=10", bus_if.bist_done, bus_if.bist_fail);
        end
    endtask

    task automatic test_bist_abort();
        int busy_cycles;
        bit finished;
        bus_if.bist_start = 1'b1;
        @(posedge clk); #1;
        bus_if.bist_start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus_if.bist_busy, bus_if.bist_done, bus_if.bist_fail} !== 3'b000) begin
            bad++;
            $display("FAIL bist_abort got busy/done/fail=%b%b%b want=000",
                     bus_if.bist_busy, bus_if.bist_done, bus_if.bist_fail);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus_if.bist_start = 1'b1;
        busy_cycles = 0;
        finished    = 1'b0;
        for (int c = 0; c < 20 && !finished; c++) begin
            @(posedge clk); #1;
            bus_if.bist_start = 1'b0;
            if (bus_if.bist_busy === 1'b1) busy_cycles++;
            if (bus_if.bist_done === 1'b1) finished = 1'b1;
        end
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL bist_restart_timeout got done=%b want=1", bus_if.bist_done);
        end
        total++;
        if (busy_cycles != 9) begin
            bad++;
            $display("FAIL bist_restart_busy got=%0d want=9", busy_cycles);
        end
        total++;
        if (bus_if.bist_fail !== 1'b0) begin
            bad++;
            $display("FAIL bist_restart_fail got=%b want=0", bus_if.bist_fail);
        end
    endtask

`else

    task automatic test_bist_disabled();
        bus_if.bist_start = 1'b1;
        {bus_if.A, bus_if.B, bus_if.Cin} = 3'b011;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.bist_start = 1'b0;
        bus_if.in_valid   = 1'b0;
        total++;
        if ({bus_if.Sum, bus_if.Cout, bus_if.out_valid} !== 3'b011) begin
            bad++;
            $display("FAIL nobist_normal got sum/cout/vld=%b%b%b want=011",
                     bus_if.Sum, bus_if.Cout, bus_if.out_valid);
        end
        for (int k = 0; k < 10; k++) begin
            total++;
            if ({bus_if.bist_busy, bus_if.bist_done, bus_if.bist_fail} !== 3'b000) begin
                bad++;
                $display("FAIL nobist_flags_%0d got busy/done/fail=%b%b%b want=000",
                         k, bus_if.bist_busy, bus_if.bist_done, bus_if.bist_fail);
            end
            @(posedge clk); #1;
        end
        {bus_if.A, bus_if.B, bus_if.Cin} = 3'b101;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        total++;
        if ({bus_if.Sum, bus_if.Cout, bus_if.out_valid} !== 3'b011) begin
            bad++;
            $display("FAIL nobist_after got sum/cout/vld=%b%b%b want=011",
                     bus_if.Sum, bus_if.Cout, bus_if.out_valid);
        end
    endtask

`endif

    initial begin
        total = 0;
        bad   = 0;
        exp_tt[0] = 2'b00; exp_tt[1] = 2'b10; exp_tt[2] = 2'b10; exp_tt[3] = 2'b01;
        exp_tt[4] = 2'b10; exp_tt[5] = 2'b01; exp_tt[6] = 2'b01; exp_tt[7] = 2'b11;
        rst               = 1'b0;
        bus_if.A          = 1'b0;
        bus_if.B          = 1'b0;
        bus_if.Cin        = 1'b0;
        bus_if.in_valid   = 1'b0;
        bus_if.bist_start = 1'b0;

        test_reset();
        test_exhaustive();
        test_hold();
        test_async_reset();
`ifdef FULL_ADDER_BIST_EN
        test_bist_pass();
        test_bist_abort();
`else
        test_bist_disabled();
`endif
        test_exhaustive();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
